// File: rtl/msr_pkg.sv
// ---------------------------------------------------------------------------
// msr_pkg
// Shared definitions for the measurement reader: timestamp width, the
// handshake FSM state encoding and the default handshake timeout.
// No ports (package).
// ---------------------------------------------------------------------------
package msr_pkg;

    localparam int MSR_WIDTH              = 24;
    localparam int DEFAULT_TIMEOUT_CYCLES = 1000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_RELEASE = 3'd3,
        ST_DONE    = 3'd4
    } msr_state_t;

endpackage

// File: rtl/sync_bit.sv
// ---------------------------------------------------------------------------
// sync_bit
// Multi-flop synchroniser for a single asynchronous level signal.
// Ports:
//   clk    - destination clock
//   rst_n  - asynchronous active-low reset, clears every stage
//   d      - asynchronous input level
//   q      - synchronised level, STAGES clk cycles after d settles
// ---------------------------------------------------------------------------
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    // Fewer than two stages gives no metastability protection, so the chain
    // is never built shorter than that.
    localparam int N = (STAGES < 2) ? 2 : STAGES;

    logic [N-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[N-2:0], d};
        end
    end

    assign q = chain[N-1];

endmodule

// File: rtl/msr_reader.sv
// ---------------------------------------------------------------------------
// msr_reader
// Four-phase request/ready handshake with an asynchronous measurement
// responder. Each accepted start raises data_req, waits for the synchronised
// ready, captures the 24-bit timestamp, drops data_req, waits for ready to
// fall, then publishes the timestamp and its difference from the previous one.
// Either wait phase aborts with a timeout pulse after TIMEOUT_CYCLES cycles.
// Ports:
//   clk          - system clock, rising edge
//   rst_n        - asynchronous active-low reset
//   start        - one-cycle request for a measurement (ignored while busy)
//   busy         - transaction in progress
//   data_req     - registered request line to the responder
//   data_rdy     - responder ready line, asynchronous to clk
//   msr_data     - responder timestamp, stable while data_rdy is high
//   result       - last captured timestamp
//   delta        - result minus previous result, modulo 2^24
//   delta_valid  - set once two captures have completed since reset
//   result_valid - one-cycle pulse when result/delta update
//   timeout      - one-cycle pulse when a handshake phase is aborted
// ---------------------------------------------------------------------------
module msr_reader
    import msr_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 data_req,
    input  logic                 data_rdy,
    input  logic [MSR_WIDTH-1:0] msr_data,
    output logic [MSR_WIDTH-1:0] result,
    output logic [MSR_WIDTH-1:0] delta,
    output logic                 delta_valid,
    output logic                 result_valid,
    output logic                 timeout
);

    localparam int                   TIMER_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_W-1:0]   TIMER_MAX = TIMER_W'(TIMEOUT_CYCLES);

    msr_state_t           state;
    logic                 rdy_s;
    logic [TIMER_W-1:0]   timer;
    logic [TIMER_W-1:0]   timer_inc;
    logic                 phase_expired;
    logic [MSR_WIDTH-1:0] capture;
    logic [MSR_WIDTH-1:0] prev;
    logic                 has_prev;

    // The only path from data_rdy into the clock domain.
    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_rdy_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (data_rdy),
        .q     (rdy_s)
    );

    // The timer counts completed cycles of the current wait phase. The phase
    // is aborted on the edge at which that count reaches TIMEOUT_CYCLES, so a
    // phase that never sees its ready condition lasts exactly TIMEOUT_CYCLES
    // cycles. The increment saturates so the counter can never wrap.
    always_comb begin
        timer_inc     = (timer == TIMER_MAX) ? timer : timer + TIMER_W'(1);
        phase_expired = (timer_inc == TIMER_MAX);
    end

    // Handshake sequencer and result datapath. result_valid and timeout are
    // single-cycle pulses defaulted low every cycle; busy and data_req are
    // registered and change on the same edges as the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            busy         <= 1'b0;
            data_req     <= 1'b0;
            timer        <= '0;
            capture      <= '0;
            prev         <= '0;
            has_prev     <= 1'b0;
            result       <= '0;
            delta        <= '0;
            delta_valid  <= 1'b0;
            result_valid <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            timeout      <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_REQ;
                        busy     <= 1'b1;
                        data_req <= 1'b1;
                        timer    <= '0;
                    end
                end

                // A ready level left over from an aborted transaction is
                // accepted here just like a fresh one.
                ST_REQ: begin
                    if (rdy_s) begin
                        state <= ST_CAPTURE;
                    end else if (phase_expired) begin
                        state    <= ST_IDLE;
                        busy     <= 1'b0;
                        data_req <= 1'b0;
                        timeout  <= 1'b1;
                    end else begin
                        timer <= timer_inc;
                    end
                end

                ST_CAPTURE: begin
                    capture  <= msr_data;
                    state    <= ST_RELEASE;
                    data_req <= 1'b0;
                    timer    <= '0;
                end

                ST_RELEASE: begin
                    if (!rdy_s) begin
                        state <= ST_DONE;
                    end else if (phase_expired) begin
                        state   <= ST_IDLE;
                        busy    <= 1'b0;
                        timeout <= 1'b1;
                    end else begin
                        timer <= timer_inc;
                    end
                end

                // delta is plain modular subtraction; the first capture after
                // reset is taken against prev=0 but is not flagged valid.
                ST_DONE: begin
                    result       <= capture;
                    delta        <= capture - prev;
                    prev         <= capture;
                    delta_valid  <= delta_valid | has_prev;
                    has_prev     <= 1'b1;
                    result_valid <= 1'b1;
                    busy         <= 1'b0;
                    state        <= ST_IDLE;
                end

                default: begin
                    state    <= ST_IDLE;
                    busy     <= 1'b0;
                    data_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_msr_reader.sv
// ---------------------------------------------------------------------------
// tb_msr_reader
// Directed bench for msr_reader with a behavioural responder and a scoreboard
// of expected result/delta/delta_valid values.
// ---------------------------------------------------------------------------
module tb_msr_reader;

    localparam int TO_CYCLES = 16;

    typedef struct {
        logic [23:0] res;
        logic [23:0] dlt;
        logic        dv;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        busy;
    logic        data_req;
    logic        data_rdy;
    logic [23:0] msr_data;
    logic [23:0] result;
    logic [23:0] delta;
    logic        delta_valid;
    logic        result_valid;
    logic        timeout;

    int          tests;
    int          fails;
    int          timeoutCount;
    int          rspMode;
    logic [2:0]  reqHist;
    exp_t        expQ[$];
    logic [23:0] modelPrev;
    logic        modelHasPrev;

    msr_reader #(
        .TIMEOUT_CYCLES (TO_CYCLES),
        .SYNC_STAGES    (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .busy         (busy),
        .data_req     (data_req),
        .data_rdy     (data_rdy),
        .msr_data     (msr_data),
        .result       (result),
        .delta        (delta),
        .delta_valid  (delta_valid),
        .result_valid (result_valid),
        .timeout      (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Responder: mode 0 follows data_req after three clocks, mode 1 never
    // raises ready, mode 2 holds ready high.
    initial begin
        reqHist  = '0;
        data_rdy = 1'b0;
    end

    always @(posedge clk) begin
        #1;
        reqHist = {reqHist[1:0], data_req};
        case (rspMode)
            0:       data_rdy = reqHist[2];
            1:       data_rdy = 1'b0;
            default: data_rdy = 1'b1;
        endcase
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every result_valid pulse must match the oldest
    // expected entry, and data_req must already be low.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && timeout === 1'b1) timeoutCount++;
        if (rst_n === 1'b1 && result_valid === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected result_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("result", {8'h0, result}, {8'h0, e.res});
                checkOutput("delta", {8'h0, delta}, {8'h0, e.dlt});
                checkOutput("delta_valid", {31'h0, delta_valid}, {31'h0, e.dv});
                checkOutput("data_req low at result_valid", {31'h0, data_req}, 32'd0);
            end
        end
    end

    // Drives one start pulse with the given timestamp presented; when a
    // completion is expected the model computes and queues its outcome.
    task automatic applyStimulus(input logic [23:0] data, input bit expectDone);
        exp_t e;
        @(negedge clk);
        msr_data = data;
        if (expectDone) begin
            e.res        = data;
            e.dlt        = data - modelPrev;
            e.dv         = modelHasPrev;
            modelPrev    = data;
            modelHasPrev = 1'b1;
            expQ.push_back(e);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulseStart();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitIdle(input int maxCycles, input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < maxCycles) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, {31'h0, (n < maxCycles)}, 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic waitReq(input logic level, input int maxCycles, input string tag);
        int n = 0;
        while (data_req !== level && n < maxCycles) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, {31'h0, (n < maxCycles)}, 32'd1);
    endtask

    initial begin
        int          cnt;
        int          guard;
        logic [23:0] savedResult;

        tests        = 0;
        fails        = 0;
        timeoutCount = 0;
        rspMode      = 0;
        modelPrev    = '0;
        modelHasPrev = 1'b0;
        rst_n        = 1'b0;
        start        = 1'b0;
        msr_data     = '0;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("reset busy", {31'h0, busy}, 32'd0);
        checkOutput("reset data_req", {31'h0, data_req}, 32'd0);
        checkOutput("reset result", {8'h0, result}, 32'd0);
        checkOutput("reset delta", {8'h0, delta}, 32'd0);
        checkOutput("reset delta_valid", {31'h0, delta_valid}, 32'd0);
        checkOutput("reset result_valid", {31'h0, result_valid}, 32'd0);
        checkOutput("reset timeout", {31'h0, timeout}, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("idle after reset busy", {31'h0, busy}, 32'd0);

        // Single measurement, then a sequence exercising delta and its wrap
        applyStimulus(24'h123456, 1'b1);
        checkOutput("busy after start", {31'h0, busy}, 32'd1);
        checkOutput("data_req after start", {31'h0, data_req}, 32'd1);
        waitIdle(200, "first transaction completes");
        applyStimulus(24'h000100, 1'b1);
        waitIdle(200, "txn 0x000100 completes");
        applyStimulus(24'h000350, 1'b1);
        waitIdle(200, "txn 0x000350 completes");
        applyStimulus(24'hFFFFF0, 1'b1);
        waitIdle(200, "txn 0xFFFFF0 completes");
        applyStimulus(24'h000010, 1'b1);
        waitIdle(200, "txn 0x000010 completes");

        // Responder never answers: REQ times out after TO_CYCLES cycles
        rspMode     = 1;
        savedResult = result;
        applyStimulus(24'hABCDEF, 1'b0);
        cnt   = 0;
        guard = 0;
        while (timeout !== 1'b1 && guard < 200) begin
            if (data_req === 1'b1) cnt++;
            @(negedge clk);
            guard++;
        end
        checkOutput("REQ timeout seen", {31'h0, (guard < 200)}, 32'd1);
        checkOutput("REQ phase length", cnt, TO_CYCLES);
        checkOutput("data_req at REQ timeout", {31'h0, data_req}, 32'd0);
        checkOutput("busy at REQ timeout", {31'h0, busy}, 32'd0);
        checkOutput("result kept on REQ timeout", {8'h0, result}, {8'h0, savedResult});
        @(negedge clk);
        checkOutput("timeout is one cycle", {31'h0, timeout}, 32'd0);
        rspMode = 0;
        repeat (8) @(negedge clk);

        // Ready stuck high: RELEASE times out, then a stale ready is accepted
        rspMode = 2;
        repeat (4) @(negedge clk);
        applyStimulus(24'h55AA55, 1'b0);
        guard = 0;
        while (timeout !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("RELEASE timeout seen", {31'h0, (guard < 200)}, 32'd1);
        checkOutput("result kept on RELEASE timeout", {8'h0, result}, {8'h0, savedResult});
        checkOutput("delta_valid kept on timeout", {31'h0, delta_valid}, 32'd1);
        applyStimulus(24'h0F0F0F, 1'b1);
        cnt = 0;
        guard = 0;
        while (data_req === 1'b1 && guard < 200) begin
            cnt++;
            @(negedge clk);
            guard++;
        end
        checkOutput("stale ready accepted at once", cnt, 2);
        rspMode = 0;
        waitIdle(200, "stale-ready transaction completes");

        // Extra starts during REQ and RELEASE are ignored
        applyStimulus(24'h222222, 1'b1);
        pulseStart();
        waitReq(1'b0, 200, "reach RELEASE for extra start");
        pulseStart();
        waitIdle(200, "transaction with extra starts completes");
        repeat (10) @(negedge clk);
        checkOutput("no transaction from ignored start", {31'h0, busy}, 32'd0);

        // Reset in RELEASE clears everything immediately
        applyStimulus(24'h333333, 1'b0);
        waitReq(1'b0, 200, "reach RELEASE before reset");
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("mid reset data_req", {31'h0, data_req}, 32'd0);
        checkOutput("mid reset busy", {31'h0, busy}, 32'd0);
        checkOutput("mid reset result", {8'h0, result}, 32'd0);
        checkOutput("mid reset delta", {8'h0, delta}, 32'd0);
        checkOutput("mid reset delta_valid", {31'h0, delta_valid}, 32'd0);
        checkOutput("mid reset result_valid", {31'h0, result_valid}, 32'd0);
        checkOutput("mid reset timeout", {31'h0, timeout}, 32'd0);
        modelPrev    = '0;
        modelHasPrev = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("no result_valid after reset", {31'h0, result_valid}, 32'd0);

        // Recovery after reset: first capture again has delta_valid low
        applyStimulus(24'h000777, 1'b1);
        waitIdle(200, "post-reset transaction completes");

        repeat (5) @(negedge clk);
        checkOutput("all expected results seen", expQ.size(), 0);
        checkOutput("timeout pulse count", timeoutCount, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/msr_reader.md
MSR_READER -- requirements
Module: msr_reader

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1000, cycles allowed per handshake phase (request, release) before abort.
REQ-002 Parameter SYNC_STAGES, default 2, flip-flop stages on the asynchronous data_rdy input (minimum 2).
REQ-003 clk  input  1  single system clock; all state is on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request for one measurement.
REQ-006 busy  output  1  high while a transaction is in progress.
REQ-007 data_req  output  1  request line to the measurement responder; registered.
REQ-008 data_rdy  input  1  responder ready line; asynchronous to clk.
REQ-009 msr_data  input  24  responder timestamp bus; stable while data_rdy is high.
REQ-010 result  output  24  last captured timestamp.
REQ-011 delta  output  24  result minus previous result, modulo 2^24.
REQ-012 delta_valid  output  1  high once two successful captures have occurred since reset.
REQ-013 result_valid  output  1  one-cycle pulse when result/delta update.
REQ-014 timeout  output  1  one-cycle pulse on handshake abort.

Function
REQ-015 data_rdy passes through SYNC_STAGES flops to form rdy_s; no other logic samples data_rdy.
REQ-016 FSM states: IDLE, REQ, CAPTURE, RELEASE, DONE.
REQ-017 IDLE: data_req=0, busy=0; start=1 -> REQ, with data_req=1 and busy=1 in the next cycle.
REQ-018 REQ: hold data_req=1; rdy_s=1 -> CAPTURE.
REQ-019 CAPTURE: lasts one cycle; msr_data is registered into a capture register; -> RELEASE.
REQ-020 RELEASE: data_req=0; rdy_s=0 -> DONE.
REQ-021 DONE: lasts one cycle; result<=capture; delta<=capture-prev (24-bit wrap); prev<=capture; result_valid=1; delta_valid<=1 if a previous capture exists; -> IDLE.
REQ-022 start while busy=1 is ignored (not queued).
REQ-023 Phase timer resets on entry to REQ and to RELEASE, and increments every cycle in those states.
REQ-024 Timer reaching TIMEOUT_CYCLES in REQ or RELEASE: data_req=0, timeout pulses 1 cycle, -> IDLE.
REQ-025 On timeout, result, delta, prev and delta_valid are unchanged, and result_valid is not asserted.
REQ-026 After a timeout, the next transaction in REQ waits for rdy_s=1 as normal; a stale high rdy_s is accepted.
REQ-027 Delta wrap: prev=0xFFFFF0, capture=0x000010 -> delta=0x000020.
REQ-028 Minimum transaction length, from the start-accepting edge to result_valid, is 4+2*SYNC_STAGES cycles.

Reset
REQ-029 rst_n=0 asynchronously forces: FSM=IDLE, data_req=0, busy=0, result=0, delta=0, prev=0, delta_valid=0, result_valid=0, timeout=0, timer=0, sync flops=0.
REQ-030 Reset asserted mid-transaction drops data_req immediately, with no result_valid or timeout pulse.
REQ-031 Deassertion of rst_n is synchronised externally; the block takes no action until the first start.

Structure
REQ-032 Shared package msr_pkg holds: MSR_WIDTH=24, the FSM state enum, and the default TIMEOUT_CYCLES.
REQ-033 Sub-module sync_bit (parameter STAGES) implements the data_rdy synchroniser; all other logic is in msr_reader.
REQ-034 The timer is $clog2(TIMEOUT_CYCLES+1) bits wide and saturates; it never wraps.

Verification
REQ-035 Behavioural responder with rdy delay of 3 cycles and msr_data=0x123456; pulse start -> result=0x123456, result_valid 1 cycle, delta_valid=0, data_req low before result_valid.
REQ-036 Two transactions, 0x000100 then 0x000350 -> delta=0x000250, delta_valid=1; then 0xFFFFF0 followed by 0x000010 -> delta=0x000020.
REQ-037 Responder never raises rdy, TIMEOUT_CYCLES=16 -> timeout pulse on cycle 16 of REQ, data_req=0, result unchanged, busy=0.
REQ-038 Responder holds rdy high forever -> timeout from RELEASE; next start with rdy still high completes immediately with the current msr_data.
REQ-039 start pulsed during REQ and RELEASE -> ignored; exactly one result_valid per accepted start.
REQ-040 rst_n low during RELEASE -> data_req=0 and all outputs at reset values in the same cycle; no result_valid or timeout pulse.
